// File: rtl/test_result_sequencer_pkg.sv
// Shared types and defaults for the regression result sequencer.
package test_result_sequencer_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StLaunch,
      StWait,
      StNext,
      StFinish
   } state_e;

   localparam int unsigned TestTimeoutW = 20;

   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/test_result_sequencer_watchdog.sv
// Free-running watchdog: counts while enabled, saturates at all-ones and flags expiry there.
module test_result_sequencer_watchdog #(
   parameter int unsigned WIDTH = 20
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   logic [WIDTH-1:0] count_q;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count_q <= '0;
      end else if (enable && !expired) begin
         count_q <= count_q + WIDTH'(1);
      end
   end

   assign expired = &count_q;

endmodule

// File: rtl/test_result_sequencer.sv
// Regression controller: launches sub-test channels (serially or together), times each out
// with a watchdog and rolls per-channel pass/fail up into done/error/first_fail.
module test_result_sequencer
   import test_result_sequencer_pkg::*;
#(
   parameter int unsigned NUM_CH       = 8,
   parameter int unsigned SEQUENTIAL   = 1,
   parameter int unsigned STOP_ON_FAIL = 0,
   parameter int unsigned TIMEOUT_W    = TestTimeoutW,
   parameter int unsigned IDX_W        = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic [NUM_CH-1:0] ch_start,
   input  logic [NUM_CH-1:0] ch_done,
   input  logic [NUM_CH-1:0] ch_error,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [NUM_CH-1:0] fail_mask,
   output logic [NUM_CH-1:0] timeout_mask,
   output logic [NUM_CH-1:0] skip_mask,
   output logic [IDX_W-1:0]  first_fail
);

   state_e            state_q;
   logic [IDX_W-1:0]  cur_q;
   logic [NUM_CH-1:0] active_q;

   logic              wd_run;
   logic              wd_clear;
   logic              wd_expired;
   logic [NUM_CH-1:0] timeout_new;
   logic [NUM_CH-1:0] complete;
   logic [NUM_CH-1:0] fail_new;
   logic [NUM_CH-1:0] still_active;
   logic [NUM_CH-1:0] later_than_cur;
   logic [IDX_W-1:0]  cur_inc;

   function automatic logic [NUM_CH-1:0] onehot(input logic [IDX_W-1:0] idx);
      logic [NUM_CH-1:0] v;
      v = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         if (idx == IDX_W'(i)) v[i] = 1'b1;
      end
      return v;
   endfunction

   // Scan downwards so the lowest set bit is the last one written.
   function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_CH-1:0] v);
      logic [IDX_W-1:0] idx;
      idx = '0;
      for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
         if (v[i]) idx = IDX_W'(i);
      end
      return idx;
   endfunction

   // A channel is only active from the cycle after its launch pulse, so stale levels
   // seen during LAUNCH never reach the masks.
   assign timeout_new  = active_q & {NUM_CH{wd_expired}};
   assign complete     = (active_q & ch_done) | timeout_new;
   assign fail_new     = (active_q & ch_error) | timeout_new;
   assign still_active = active_q & ~complete;
   assign cur_inc      = cur_q + IDX_W'(1);

   always_comb begin
      later_than_cur = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         later_than_cur[i] = (IDX_W'(i) > cur_q);
      end
   end

   assign wd_run   = (state_q == StLaunch) || (state_q == StWait);
   assign wd_clear = !wd_run;

   test_result_sequencer_watchdog #(
      .WIDTH(TIMEOUT_W)
   ) u_watchdog (
      .clk    (clk),
      .reset  (reset),
      .clear  (wd_clear),
      .enable (wd_run),
      .expired(wd_expired)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StIdle;
         cur_q        <= '0;
         active_q     <= '0;
         ch_start     <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         error        <= 1'b0;
         fail_mask    <= '0;
         timeout_mask <= '0;
         skip_mask    <= '0;
         first_fail   <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  fail_mask    <= '0;
                  timeout_mask <= '0;
                  skip_mask    <= '0;
                  done         <= 1'b0;
                  error        <= 1'b0;
                  first_fail   <= '0;
                  busy         <= 1'b1;
                  cur_q        <= '0;
                  ch_start     <= (SEQUENTIAL != 0) ? onehot(IDX_W'(0)) : '1;
                  state_q      <= StLaunch;
               end
            end
            StLaunch: begin
               active_q <= ch_start;
               ch_start <= '0;
               state_q  <= StWait;
            end
            StWait: begin
               active_q     <= still_active;
               fail_mask    <= fail_mask | fail_new;
               timeout_mask <= timeout_mask | timeout_new;
               if (still_active == '0) begin
                  state_q <= (SEQUENTIAL != 0) ? StNext : StFinish;
               end
            end
            StNext: begin
               if (cur_q == IDX_W'(NUM_CH - 1)) begin
                  state_q <= StFinish;
               end else if ((STOP_ON_FAIL != 0) && (fail_mask != '0)) begin
                  skip_mask <= later_than_cur;
                  state_q   <= StFinish;
               end else begin
                  cur_q    <= cur_inc;
                  ch_start <= onehot(cur_inc);
                  state_q  <= StLaunch;
               end
            end
            StFinish: begin
               done       <= 1'b1;
               busy       <= 1'b0;
               error      <= |fail_mask;
               first_fail <= lowest_set(fail_mask);
               state_q    <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_test_result_sequencer.sv
// Randomized bench: three sequencer flavours (sequential, stop-on-fail, concurrent) driven by
// emulated channels and checked against a cycle-count reference model.
module tb_test_result_sequencer;

   localparam int NCH       = 4;
   localparam int IW        = 3;
   localparam int TW        = 6;
   localparam int WD_LIMIT  = (1 << TW) - 1;
   localparam int NEVER     = 1000;
   localparam int NDUT      = 3;
   localparam int NRUN      = 24;
   localparam int ABORT_RUN = 4;
   localparam int BUDGET    = 400;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           reset;
   logic           start;
   logic [NCH-1:0] ch_start     [NDUT];
   logic [NCH-1:0] ch_done      [NDUT];
   logic [NCH-1:0] ch_error     [NDUT];
   logic           busy         [NDUT];
   logic           done         [NDUT];
   logic           error        [NDUT];
   logic [NCH-1:0] fail_mask    [NDUT];
   logic [NCH-1:0] timeout_mask [NDUT];
   logic [NCH-1:0] skip_mask    [NDUT];
   logic [IW-1:0]  first_fail   [NDUT];

   test_result_sequencer #(
      .NUM_CH(NCH), .SEQUENTIAL(1), .STOP_ON_FAIL(0), .TIMEOUT_W(TW), .IDX_W(IW)
   ) u_seq (
      .clk(clk), .reset(reset), .start(start), .ch_start(ch_start[0]), .ch_done(ch_done[0]),
      .ch_error(ch_error[0]), .busy(busy[0]), .done(done[0]), .error(error[0]),
      .fail_mask(fail_mask[0]), .timeout_mask(timeout_mask[0]), .skip_mask(skip_mask[0]),
      .first_fail(first_fail[0])
   );

   test_result_sequencer #(
      .NUM_CH(NCH), .SEQUENTIAL(1), .STOP_ON_FAIL(1), .TIMEOUT_W(TW), .IDX_W(IW)
   ) u_sof (
      .clk(clk), .reset(reset), .start(start), .ch_start(ch_start[1]), .ch_done(ch_done[1]),
      .ch_error(ch_error[1]), .busy(busy[1]), .done(done[1]), .error(error[1]),
      .fail_mask(fail_mask[1]), .timeout_mask(timeout_mask[1]), .skip_mask(skip_mask[1]),
      .first_fail(first_fail[1])
   );

   test_result_sequencer #(
      .NUM_CH(NCH), .SEQUENTIAL(0), .STOP_ON_FAIL(0), .TIMEOUT_W(TW), .IDX_W(IW)
   ) u_con (
      .clk(clk), .reset(reset), .start(start), .ch_start(ch_start[2]), .ch_done(ch_done[2]),
      .ch_error(ch_error[2]), .busy(busy[2]), .done(done[2]), .error(error[2]),
      .fail_mask(fail_mask[2]), .timeout_mask(timeout_mask[2]), .skip_mask(skip_mask[2]),
      .first_fail(first_fail[2])
   );

   int             n_checks = 0;
   int             n_pass   = 0;
   int             cyc      = 0;
   int             age      [NDUT][NCH];
   int             cfg_d    [NCH];
   int             cfg_e    [NCH];
   bit             cfg_hold [NCH];
   int             rec_n    [NDUT];
   int             rec_cyc  [NDUT][8];
   logic [NCH-1:0] rec_mask [NDUT][8];
   int             done_cyc [NDUT];
   string          dname    [NDUT] = '{"seq", "sof", "con"};

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   function automatic logic [31:0] outs(input int k);
      return 32'({ch_start[k], busy[k], done[k], error[k], fail_mask[k], timeout_mask[k],
                  skip_mask[k], first_fail[k]});
   endfunction

   // One cycle: land on the falling edge, then advance every emulated channel. A channel
   // restarts on its launch pulse and otherwise keeps its done/error levels.
   task automatic step();
      @(negedge clk);
      cyc++;
      for (int k = 0; k < NDUT; k++) begin
         for (int c = 0; c < NCH; c++) begin
            if (ch_start[k][c] === 1'b1) begin
               age[k][c]      = 0;
               ch_done[k][c]  = 1'b0;
               ch_error[k][c] = 1'b0;
            end else if (age[k][c] >= 0) begin
               age[k][c]++;
               if (age[k][c] >= cfg_d[c]) ch_done[k][c] = 1'b1;
               if (cfg_e[c] != 0 && age[k][c] == cfg_e[c]) ch_error[k][c] = 1'b1;
               else if (!cfg_hold[c]) ch_error[k][c] = 1'b0;
            end
         end
      end
   endtask

   task automatic set_cfg(input int run);
      int lim;
      for (int c = 0; c < NCH; c++) begin
         cfg_d[c]    = 3;
         cfg_e[c]    = 0;
         cfg_hold[c] = 1'b0;
      end
      case (run)
         0: ;
         1: cfg_e[2] = 1;
         2: begin cfg_e[1] = 3; cfg_hold[1] = 1'b1; end
         3: cfg_d[3] = NEVER;
         4: for (int c = 0; c < NCH; c++) cfg_d[c] = 8;
         default: begin
            for (int c = 0; c < NCH; c++) begin
               cfg_d[c] = (int'($urandom_range(6)) == 0) ? NEVER : 1 + int'($urandom_range(11));
               lim = (cfg_d[c] > 12) ? 12 : cfg_d[c];
               cfg_e[c] = (int'($urandom_range(3)) == 0) ? 1 + int'($urandom_range(lim - 1)) : 0;
               cfg_hold[c] = 1'($urandom_range(1));
            end
         end
      endcase
   endtask

   // Reference: each channel takes min(done delay, watchdog limit) cycles after its launch;
   // serial channels cost two extra cycles each, a concurrent run waits for the slowest one.
   task automatic check_dut(input int k, input int s, input int run);
      logic [NCH-1:0] f, t, sk;
      int             l, n, mx, comp, ff;
      bit             stop;
      string          p;
      p  = $sformatf("%s run%0d", dname[k], run);
      f  = '0;
      t  = '0;
      sk = '0;
      n  = 0;
      mx = 0;
      stop = 1'b0;
      l  = s + 1;
      for (int c = 0; c < NCH; c++) begin
         comp = (cfg_d[c] == NEVER) ? WD_LIMIT : cfg_d[c];
         if (k == 2 || !stop) begin
            t[c] = (cfg_d[c] == NEVER);
            f[c] = t[c] || (cfg_e[c] != 0);
         end
         if (k == 2) begin
            if (comp > mx) mx = comp;
         end else if (stop) begin
            sk[c] = 1'b1;
         end else begin
            check_eq({p, " launch cycle"}, rec_cyc[k][n], l);
            check_eq({p, " launch mask"}, rec_mask[k][n], 32'(1) << c);
            n++;
            l = l + comp + 2;
            if (k == 1 && f[c]) stop = 1'b1;
         end
      end
      if (k == 2) begin
         check_eq({p, " launch cycle"}, rec_cyc[k][0], l);
         check_eq({p, " launch mask"}, rec_mask[k][0], {NCH{1'b1}});
         n = 1;
         l = s + 1 + mx + 2;
      end else begin
         l = l + 1;
      end
      ff = 0;
      for (int c = NCH - 1; c >= 0; c--) if (f[c]) ff = c;
      check_eq({p, " launch count"}, rec_n[k], n);
      check_eq({p, " done cycle"}, done_cyc[k], l);
      check_eq({p, " fail_mask"}, fail_mask[k], f);
      check_eq({p, " timeout_mask"}, timeout_mask[k], t);
      check_eq({p, " skip_mask"}, skip_mask[k], sk);
      check_eq({p, " error"}, error[k], |f);
      check_eq({p, " first_fail"}, first_fail[k], ff);
      check_eq({p, " busy"}, busy[k], 0);
   endtask

   initial begin
      int s;
      bit aborted;
      reset = 1'b1;
      start = 1'b0;
      for (int k = 0; k < NDUT; k++) begin
         ch_done[k]  = '0;
         ch_error[k] = '0;
         for (int c = 0; c < NCH; c++) age[k][c] = -1;
      end
      set_cfg(0);
      repeat (3) step();
      for (int k = 0; k < NDUT; k++) check_eq({dname[k], " reset state"}, outs(k), 0);
      reset = 1'b0;

      for (int run = 0; run < NRUN; run++) begin
         set_cfg(run);
         for (int k = 0; k < NDUT; k++) begin
            rec_n[k]    = 0;
            done_cyc[k] = -1;
            for (int i = 0; i < 8; i++) begin
               rec_cyc[k][i]  = -1;
               rec_mask[k][i] = '0;
            end
         end
         aborted = 1'b0;
         step();
         start = 1'b1;
         s = cyc;
         for (int t = 0; t < BUDGET; t++) begin
            step();
            start = 1'b0;
            for (int k = 0; k < NDUT; k++) begin
               if (ch_start[k] != '0) begin
                  if (rec_n[k] < 8) begin
                     rec_cyc[k][rec_n[k]]  = cyc;
                     rec_mask[k][rec_n[k]] = ch_start[k];
                  end
                  rec_n[k]++;
               end
               if (done_cyc[k] < 0 && done[k] === 1'b1) done_cyc[k] = cyc;
               if (t == 0) check_eq($sformatf("%s run%0d busy/done at launch", dname[k], run),
                                    {busy[k], done[k]}, 2'b10);
            end
            if (run == ABORT_RUN && t == 3) begin
               reset = 1'b1;
               step();
               for (int k = 0; k < NDUT; k++)
                  check_eq({dname[k], " mid-run reset"}, outs(k), 0);
               reset = 1'b0;
               aborted = 1'b1;
               break;
            end
            if (done_cyc[0] >= 0 && done_cyc[1] >= 0 && done_cyc[2] >= 0) break;
            // A start seen while a run is in flight must be ignored.
            if (busy[0] && busy[1] && busy[2] && (t == 2 || $urandom_range(7) == 0))
               start = 1'b1;
         end
         start = 1'b0;
         if (!aborted) begin
            for (int k = 0; k < NDUT; k++) check_dut(k, s, run);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
